// File: rtl/to_upper_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : to_upper_sched                                                   |
// | Brief   : Round-robin scheduler sharing one toUpper converter between two  |
// |           requesters, with settle-time hold and valid/ready output.        |
// |           Optional conv_count statistics via TO_UPPER_SCHED_STATS_EN.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

module to_upper (
    input  logic [7:0] i_char,
    output logic [7:0] o_char
);
    // Only 'a'..'z' are shifted; everything else, including extended codes, passes.
    assign o_char = (i_char >= 8'd97 && i_char <= 8'd122) ? (i_char - 8'd32) : i_char;
endmodule

module to_upper_sched #(
    parameter int SETTLE_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_src,
    input  logic        out_ready,
    output logic        busy
`ifdef TO_UPPER_SCHED_STATS_EN
    ,
    output logic [15:0] conv_count
`endif
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("to_upper_sched: SETTLE_CYCLES must be in 1..255");
        end
    endgenerate

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SETTLE   = 2'd1;
    localparam logic [1:0] c_OUT      = 2'd2;
    localparam logic [7:0] c_CNT_INIT = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_in;
    logic        r_src;
    logic        r_last_grant;
    logic [7:0]  r_cnt;
    logic [7:0]  r_out_data;
    logic        r_out_src;
    logic        r_busy;
    logic [7:0]  w_conv;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_idle;

    to_upper u_to_upper (
        .i_char (r_in),
        .o_char (w_conv)
    );

    // On contention the channel that did not win last time takes the turn.
    assign w_idle     = (r_state == c_IDLE);
    assign w_grant0   = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1   = req1_valid && (!req0_valid || !r_last_grant);
    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign out_valid  = (r_state == c_OUT);
    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign busy       = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_grant0 || w_grant1) w_state_nxt = c_SETTLE;
            c_SETTLE: if (r_cnt == 8'd0)        w_state_nxt = c_OUT;
            c_OUT:    if (out_ready)            w_state_nxt = c_IDLE;
            default:                            w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_in         <= 8'h00;
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 8'd0;
            r_out_data   <= 8'h00;
            r_out_src    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_in         <= w_grant1 ? req1_data : req0_data;
                        r_src        <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_cnt        <= c_CNT_INIT;
                    end
                end
                c_SETTLE: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_out_data <= w_conv;
                        r_out_src  <= r_src;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TO_UPPER_SCHED_STATS_EN
    logic [15:0] r_conv_count;

    // Counted at the capture edge, saturating; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conv_count <= 16'd0;
        end else if (r_state == c_SETTLE && r_cnt == 8'd0 && w_conv != r_in
                     && r_conv_count != 16'hFFFF) begin
            r_conv_count <= r_conv_count + 16'd1;
        end
    end

    assign conv_count = r_conv_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_to_upper_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_to_upper_sched                                                |
// | Brief   : Scoreboard bench for to_upper_sched (directed vectors).          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

module tb_to_upper_sched;

    localparam int c_S = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_data = 8'h00;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_data = 8'h00;
    logic        req1_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_src;
    logic        out_ready = 1'b1;
    logic        busy;
`ifdef TO_UPPER_SCHED_STATS_EN
    logic [15:0] conv_count;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [8:0]  q[$];

    always #5 clk = ~clk;

    to_upper_sched #(.SETTLE_CYCLES(c_S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .busy       (busy)
`ifdef TO_UPPER_SCHED_STATS_EN
        ,
        .conv_count (conv_count)
`endif
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got data %0d src %0d expected none", out_data, out_src);
            end else begin
                logic [8:0] e;
                e = q.pop_front();
                chk("out_data", {8'd0, out_data}, {8'd0, e[7:0]});
                chk("out_src", {15'd0, out_src}, {15'd0, e[8]});
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input bit ch, input logic [7:0] d, input logic [7:0] exp);
        int t = 0;
        if (ch) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        @(negedge clk);
        while (!(ch ? req1_ready : req0_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", {15'd0, t < 100}, 16'd1);
        q.push_back({ch, exp});
        @(posedge clk);
        #1;
        if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", {15'd0, t < 200}, 16'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [7:0] sweep_in  [8] = '{8'd96, 8'd97, 8'd122, 8'd123, 8'd64, 8'd65, 8'd183, 8'd127};
    logic [7:0] sweep_exp [8] = '{8'd96, 8'd65, 8'd90,  8'd123, 8'd64, 8'd65, 8'd183, 8'd127};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", {8'd0, out_data}, 16'd0);
        chk("rst_out_src", {15'd0, out_src}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ready", {14'd0, req1_ready, req0_ready}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single conversion with latency / busy-span checks
        req0_valid = 1'b1;
        req0_data  = 8'd97;
        @(negedge clk);
        chk("single_ready", {15'd0, req0_ready}, 16'd1);
        q.push_back({1'b0, 8'd65});
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("single_ready_drop", {15'd0, req0_ready}, 16'd0);
        chk("single_busy_1", {15'd0, busy}, 16'd1);
        chk("single_valid_1", {15'd0, out_valid}, 16'd0);
        for (int k = 2; k <= c_S + 1; k++) begin
            @(negedge clk);
            chk("single_busy", {15'd0, busy}, 16'd1);
            chk("single_valid", {15'd0, out_valid}, {15'd0, k == c_S + 1});
        end
        @(negedge clk);
        chk("single_busy_end", {15'd0, busy}, 16'd0);
        chk("single_valid_end", {15'd0, out_valid}, 16'd0);
        drain();

        // Boundary sweep on channel 1
        for (int i = 0; i < 8; i++) send(1'b1, sweep_in[i], sweep_exp[i]);
        drain();

        // Contention from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 8'd109;
        req1_valid = 1'b1; req1_data = 8'd72;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int t = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("grant_wait", {15'd0, t < 100}, 16'd1);
            chk("grant_order", {14'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 16'd1 : 16'd2);
            q.push_back((i % 2 == 0) ? {1'b0, 8'd77} : {1'b1, 8'd72});
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Backpressure: hold output, block requesters, then release
        begin
            int t = 0;
            out_ready = 1'b0;
            send(1'b0, 8'd122, 8'd90);
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("bp_valid_wait", {15'd0, t < 100}, 16'd1);
            req1_valid = 1'b1;
            req1_data  = 8'd98;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("bp_data", {8'd0, out_data}, 16'd90);
                chk("bp_src", {15'd0, out_src}, 16'd0);
                chk("bp_ready", {14'd0, req1_ready, req0_ready}, 16'd0);
                chk("bp_valid", {15'd0, out_valid}, 16'd1);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_next_accept", {15'd0, req1_ready}, 16'd1);
            q.push_back({1'b1, 8'd66});
            @(posedge clk);
            #1 req1_valid = 1'b0;
            drain();
        end

        // Reset two cycles into SETTLE
        begin
            logic seen;
            seen = 1'b0;
            send(1'b0, 8'd97, 8'd65);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b0;
            void'(q.pop_back());
            #1;
            chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
            chk("mid_rst_busy", {15'd0, busy}, 16'd0);
            chk("mid_rst_data", {8'd0, out_data}, 16'd0);
            chk("mid_rst_src", {15'd0, out_src}, 16'd0);
            chk("mid_rst_ready", {14'd0, req1_ready, req0_ready}, 16'd0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                seen = seen | out_valid;
            end
            chk("mid_rst_no_out", {15'd0, seen}, 16'd0);
            @(posedge clk);
            #1;
            send(1'b1, 8'd113, 8'd81);
            drain();
        end

`ifdef TO_UPPER_SCHED_STATS_EN
        do_reset();
        chk("stats_reset", conv_count, 16'd0);
        send(1'b0, 8'd97, 8'd65);
        send(1'b0, 8'd65, 8'd65);
        send(1'b1, 8'd122, 8'd90);
        send(1'b1, 8'd200, 8'd200);
        drain();
        chk("stats_count", conv_count, 16'd2);
`endif

        chk("scoreboard_empty", 16'(q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
